// File: rtl/mc_ctrl_if.sv
// Memory handshake bundle between mc_ctrl and the instruction/data memories.
// Handshake: the controller raises a *_req and holds it, with all qualifying
// controls stable, until the memory answers with *_ready in the same cycle; the
// transfer completes on the rising edge where req and ready are both high.
// ready outside an active request is ignored.
interface mc_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;

  modport master (output imem_req, output dmem_req, input imem_ready, input dmem_ready);
  modport slave  (input imem_req, input dmem_req, output imem_ready, output dmem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with the
// memories, drives datapath selects, counts retirements and flags illegal ops.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  mc_ctrl_if.master        mem,
  output logic             IRWrite,
  output logic             MDRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             EXTOp,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    K_ILL, K_RALU, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR
  } kind_e;

  localparam logic [3:0] ALU_NOP = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB = 4'b0010,
                         ALU_AND = 4'b0011, ALU_OR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_NOR = 4'b1000;
  localparam logic [1:0] NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_R31 = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;

  kind_e      kind;
  logic [3:0] d_aluop;
  logic       d_alusrc, d_extop;
  logic [1:0] d_gprsel, d_wdsel;
  logic       sel_en;

  // Instruction decode: class plus the single-cycle datapath selects.
  always_comb begin
    kind     = K_ILL;
    d_aluop  = ALU_NOP;
    d_alusrc = 1'b0;
    d_extop  = 1'b0;
    d_gprsel = GPR_RD;
    d_wdsel  = WD_ALU;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100000, 6'b100001: begin kind = K_RALU; d_aluop = ALU_ADD;  end
          6'b100010, 6'b100011: begin kind = K_RALU; d_aluop = ALU_SUB;  end
          6'b100100:            begin kind = K_RALU; d_aluop = ALU_AND;  end
          6'b100101:            begin kind = K_RALU; d_aluop = ALU_OR;   end
          6'b100111:            begin kind = K_RALU; d_aluop = ALU_NOR;  end
          6'b101010:            begin kind = K_RALU; d_aluop = ALU_SLT;  end
          6'b101011:            begin kind = K_RALU; d_aluop = ALU_SLTU; end
          6'b001000:            kind = K_JR;
          default:              kind = K_ILL;
        endcase
      end
      6'b001000: begin kind = K_ADDI; d_aluop = ALU_ADD; d_alusrc = 1'b1; d_extop = 1'b1; d_gprsel = GPR_RT; end
      6'b001101: begin kind = K_ORI;  d_aluop = ALU_OR;  d_alusrc = 1'b1; d_gprsel = GPR_RT; end
      6'b100011: begin
        kind = K_LW; d_aluop = ALU_ADD; d_alusrc = 1'b1; d_extop = 1'b1;
        d_gprsel = GPR_RT; d_wdsel = WD_MEM;
      end
      6'b101011: begin kind = K_SW;  d_aluop = ALU_ADD; d_alusrc = 1'b1; d_extop = 1'b1; end
      6'b000100: begin kind = K_BEQ; d_aluop = ALU_SUB; end
      6'b000101: begin kind = K_BNE; d_aluop = ALU_SUB; end
      6'b000010: kind = K_J;
      6'b000011: begin kind = K_JAL; d_gprsel = GPR_R31; d_wdsel = WD_PC; end
      default:   kind = K_ILL;
    endcase
  end

  // Next-state and control outputs; everything defaults to 0 so NPCOp is
  // PLUS4 whenever the PC is not written.
  always_comb begin
    state_d      = state_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    IRWrite      = 1'b0;
    MDRWrite     = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    NPCOp        = NPC_PLUS4;
    sel_en       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        sel_en = 1'b1;
        if (kind == K_ILL) begin
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        sel_en = 1'b1;
        case (kind)
          K_LW, K_SW: state_d = S_MEM;
          K_BEQ: begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
            state_d = S_FETCH;
          end
          K_BNE: begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? NPC_PLUS4 : NPC_BRANCH;
            state_d = S_FETCH;
          end
          K_J: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JUMP;
            state_d = S_FETCH;
          end
          K_JAL: begin
            PCWrite  = 1'b1;
            RegWrite = 1'b1;
            NPCOp    = NPC_JUMP;
            state_d  = S_FETCH;
          end
          K_JR: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JR;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        sel_en       = 1'b1;
        mem.dmem_req = 1'b1;
        MemWrite     = (kind == K_SW);
        if (mem.dmem_ready) begin
          if (kind == K_SW) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            MDRWrite = 1'b1;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        sel_en   = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath selects are only driven once the IR holds a decoded instruction.
  assign ALUOp  = sel_en ? d_aluop  : ALU_NOP;
  assign ALUSrc = sel_en & d_alusrc;
  assign EXTOp  = sel_en & d_extop;
  assign GPRSel = sel_en ? d_gprsel : GPR_RD;
  assign WDSel  = sel_en ? d_wdsel  : WD_ALU;

  assign retire      = PCWrite;
  assign instret     = instret_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

  assign instret_d = PCWrite ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
  assign illegal_d = illegal_q | ((state_q == S_DECODE) && (kind == K_ILL));

  // State, retirement counter and sticky illegal flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control vectors for each
// instruction class, memory wait states and asynchronous reset.
module tb_mc_ctrl;

  logic        clk;
  logic        rstn;
  logic [5:0]  Op, Funct;
  logic        Zero;
  logic        IRWrite, MDRWrite, PCWrite, RegWrite, MemWrite, EXTOp, ALUSrc;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOp, GPRSel, WDSel;
  logic        retire, illegal;
  logic [31:0] instret;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  mc_ctrl_if mif();

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem(mif),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .retire(retire), .instret(instret),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // Observed vector: state, 9 strobes/selects, ALUOp, NPCOp, GPRSel, WDSel, retire.
  logic [22:0] obs;
  assign obs = {dbg_state, mif.imem_req, mif.dmem_req, IRWrite, MDRWrite, PCWrite,
                RegWrite, MemWrite, EXTOp, ALUSrc, ALUOp, NPCOp, GPRSel, WDSel, retire};

  localparam logic [22:0] V_IDLE  = 23'd0;
  localparam logic [22:0] V_FETCH = {3'd1, 9'b101000000, 11'b0};
  localparam logic [22:0] V_FWAIT = {3'd1, 9'b100000000, 11'b0};

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
    mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1;
    tick(); tick();
    total++;
    if (obs !== V_IDLE) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, V_IDLE); end
    total++;
    if (instret !== 32'd0 || illegal !== 1'b0) begin
      bad++; $display("FAIL reset_counters: got instret=%0d illegal=%b want 0 0", instret, illegal);
    end
    rstn = 1'b1;
    #1;
    total++;
    if (obs !== V_IDLE) begin bad++; $display("FAIL reset_release_idle: got %b want %b", obs, V_IDLE); end
    tick();
  endtask

  task automatic test_add();
    logic [22:0] exp [4];
    exp[0] = V_FETCH;
    exp[1] = {3'd2, 9'b000000000, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[2] = {3'd3, 9'b000000000, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[3] = {3'd5, 9'b000011000, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b1};
    Op = 6'b000000; Funct = 6'b100000;
    for (int c = 0; c < 4; c++) begin
      mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1;
      #1;
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL add_cyc%0d: got %b want %b", c, obs, exp[c]); end
      tick();
    end
    total++;
    if (instret !== 32'd1) begin bad++; $display("FAIL add_instret: got %0d want 1", instret); end
  endtask

  task automatic test_lw_wait();
    logic [22:0] exp [8];
    exp[0] = V_FETCH;
    exp[1] = {3'd2, 9'b000000011, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b0};
    exp[2] = {3'd3, 9'b000000011, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b0};
    exp[3] = {3'd4, 9'b010000011, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b0};
    exp[4] = exp[3];
    exp[5] = exp[3];
    exp[6] = {3'd4, 9'b010100011, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b0};
    exp[7] = {3'd5, 9'b000011011, 4'b0001, 2'b00, 2'b01, 2'b01, 1'b1};
    Op = 6'b100011; Funct = 6'b000000;
    for (int c = 0; c < 8; c++) begin
      mif.imem_ready = 1'b1;
      mif.dmem_ready = (c >= 6);
      #1;
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL lw_cyc%0d: got %b want %b", c, obs, exp[c]); end
      tick();
    end
    total++;
    if (instret !== 32'd2) begin bad++; $display("FAIL lw_instret: got %0d want 2", instret); end
  endtask

  task automatic test_branch();
    logic [22:0] exp [10];
    exp[0] = V_FWAIT;
    exp[1] = V_FETCH;
    exp[2] = {3'd2, 9'b000000000, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[3] = {3'd3, 9'b000010000, 4'b0010, 2'b01, 2'b00, 2'b00, 1'b1};
    exp[4] = V_FETCH;
    exp[5] = exp[2];
    exp[6] = {3'd3, 9'b000010000, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b1};
    exp[7] = V_FETCH;
    exp[8] = exp[2];
    exp[9] = {3'd3, 9'b000010000, 4'b0010, 2'b01, 2'b00, 2'b00, 1'b1};
    Funct = 6'b000000;
    for (int c = 0; c < 10; c++) begin
      Op = (c < 7) ? 6'b000100 : 6'b000101;
      Zero = (c < 4);
      mif.imem_ready = (c != 0);
      mif.dmem_ready = 1'b1;
      #1;
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL branch_cyc%0d: got %b want %b", c, obs, exp[c]); end
      tick();
    end
    total++;
    if (instret !== 32'd5) begin bad++; $display("FAIL branch_instret: got %0d want 5", instret); end
  endtask

  task automatic test_jal();
    logic [22:0] exp [3];
    exp[0] = V_FETCH;
    exp[1] = {3'd2, 9'b000000000, 4'b0000, 2'b00, 2'b10, 2'b10, 1'b0};
    exp[2] = {3'd3, 9'b000011000, 4'b0000, 2'b10, 2'b10, 2'b10, 1'b1};
    Op = 6'b000011; Funct = 6'b000000; Zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mif.imem_ready = 1'b1; mif.dmem_ready = 1'b0;
      #1;
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL jal_cyc%0d: got %b want %b", c, obs, exp[c]); end
      tick();
    end
  endtask

  task automatic test_illegal_then_sw();
    logic [22:0] exp [6];
    exp[0] = V_FETCH;
    exp[1] = {3'd2, 9'b000010000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1};
    exp[2] = V_FETCH;
    exp[3] = {3'd2, 9'b000000011, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[4] = {3'd3, 9'b000000011, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[5] = {3'd4, 9'b010010111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b1};
    Funct = 6'b000000;
    for (int c = 0; c < 6; c++) begin
      Op = (c < 2) ? 6'b111111 : 6'b101011;
      mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1;
      #1;
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL illsw_cyc%0d: got %b want %b", c, obs, exp[c]); end
      tick();
      if (c == 1) begin
        total++;
        if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_set: got %b want 1", illegal); end
      end
    end
    total++;
    if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
    total++;
    if (instret !== 32'd8) begin bad++; $display("FAIL illsw_instret: got %0d want 8", instret); end
  endtask

  task automatic test_reset_mid();
    logic [22:0] exp [4];
    exp[0] = V_FETCH;
    exp[1] = {3'd2, 9'b000000011, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[2] = {3'd3, 9'b000000011, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    exp[3] = {3'd4, 9'b010000111, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0};
    Op = 6'b101011; Funct = 6'b000000;
    for (int c = 0; c < 4; c++) begin
      mif.imem_ready = 1'b1; mif.dmem_ready = 1'b0;
      #1;
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL rstmid_cyc%0d: got %b want %b", c, obs, exp[c]); end
      if (c < 3) tick();
    end
    // Still inside the MEM cycle: pull reset between clock edges.
    rstn = 1'b0;
    #1;
    total++;
    if (obs !== V_IDLE) begin bad++; $display("FAIL rstmid_async_drop: got %b want %b", obs, V_IDLE); end
    total++;
    if (instret !== 32'd0 || illegal !== 1'b0) begin
      bad++; $display("FAIL rstmid_counters: got instret=%0d illegal=%b want 0 0", instret, illegal);
    end
    tick();
    rstn = 1'b1;
    #1;
    total++;
    if (obs !== V_IDLE) begin bad++; $display("FAIL rstmid_idle_after: got %b want %b", obs, V_IDLE); end
    mif.imem_ready = 1'b1;
    tick();
    total++;
    if (obs !== V_FETCH) begin bad++; $display("FAIL rstmid_refetch: got %b want %b", obs, V_FETCH); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jal();
    test_illegal_then_sw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS-subset datapath. It replaces the single-cycle decoder when instruction and data memories have variable latency. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with both memories, and drives the existing datapath control encodings (ALUOp, NPCOp, GPRSel, WDSel). It also counts retired instructions and flags unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `Op` input 6: IR[31:26], from the instruction register.
- `Funct` input 6: IR[5:0].
- `Zero` input 1: ALU zero flag.
- `imem_ready` input 1: instruction memory data valid.
- `dmem_ready` input 1: data memory access complete.
- `imem_req` output 1: instruction fetch request.
- `dmem_req` output 1: data memory request.
- `IRWrite` output 1: load IR from imem.
- `MDRWrite` output 1: load memory data register.
- `PCWrite` output 1: update PC with NPC.
- `RegWrite` output 1: register file write strobe.
- `MemWrite` output 1: data memory write (qualifies `dmem_req`).
- `EXTOp` output 1: sign-extend the immediate.
- `ALUSrc` output 1: ALU B operand from the immediate.
- `ALUOp` output 4: ALU operation.
- `NPCOp` output 2: next-PC select.
- `GPRSel` output 2: destination register select.
- `WDSel` output 2: register write-data select.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `instret` output CNT_W: retired-instruction count.
- `illegal` output 1: sticky flag, set on an unsupported instruction.

## Operation
- Encodings:
  - ALUOp: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, NOR 1000.
  - NPCOp: PLUS4 00, BRANCH 01, JUMP 10, JR 11.
  - GPRSel: RD 00, RT 01, R31 10.
  - WDSel: ALU 00, MEM 01, PC 10.
- Supported instructions:
  - R-type (Op=0): add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, nor 100111, slt 101010, sltu 101011, jr 001000.
  - I/J-type: addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
  - Anything else is illegal.
- Decode selects:
  - ALUOp, ALUSrc, EXTOp, GPRSel and WDSel follow the single-cycle mapping.
  - add/addu/addi/lw/sw use ADD; sub/subu/beq/bne use SUB; ori uses OR.
  - These selects are combinational from Op/Funct in DECODE, EXEC, MEM and WB. They are 0 in IDLE and FETCH.
- States:
  - IDLE: reset state; all outputs 0. Goes to FETCH unconditionally.
  - FETCH: `imem_req`=1. When `imem_ready`=1: assert `IRWrite`, go to DECODE. Otherwise stay.
  - DECODE: register operands are read. Legal instruction: go to EXEC. Illegal: `PCWrite`=1 with NPCOp=PLUS4, set `illegal`, go to FETCH.
  - EXEC, by instruction:
    - R-type ALU ops, addi, ori: go to WB.
    - lw, sw: go to MEM.
    - beq: `PCWrite`=1, NPCOp=BRANCH if Zero else PLUS4; go to FETCH.
    - bne: same as beq with the Zero test inverted; go to FETCH.
    - j: `PCWrite`=1, NPCOp=JUMP; go to FETCH.
    - jal: `PCWrite`=1, NPCOp=JUMP, `RegWrite`=1, GPRSel=R31, WDSel=PC; go to FETCH.
    - jr: `PCWrite`=1, NPCOp=JR; go to FETCH.
  - MEM: `dmem_req`=1, and `MemWrite`=1 for sw. When `dmem_ready`=1:
    - sw: `PCWrite`=1 with PLUS4, go to FETCH.
    - lw: `MDRWrite`=1, go to WB.
    - Otherwise stay, holding all outputs stable.
  - WB: `RegWrite`=1 (GPRSel and WDSel per instruction); `PCWrite`=1 with PLUS4; go to FETCH.
- NPCOp is 00 in every cycle where `PCWrite`=0.
- `retire` equals `PCWrite`.
- `instret` increments by 1 on every `retire` and wraps modulo 2^CNT_W.
- `illegal` clears only on reset.

## Timing
- Asynchronous reset (`rstn` low):
  - state=IDLE, `instret`=0, `illegal`=0.
  - Every output reads 0 while reset is held and in the first cycle after release.
- Reset asserted mid-instruction:
  - State aborts immediately to IDLE.
  - Any pending memory request drops the same instant; no `PCWrite` or `RegWrite` occurs.
- Cycles per instruction with zero-wait memories (ready in the same cycle as req):
  - j/jal/jr/beq/bne: 3.
  - R-type/addi/ori/sw: 4.
  - lw: 5.
  - illegal: 2.
  - Each wait cycle of `imem_ready`/`dmem_ready` adds 1.
- `imem_ready`/`dmem_ready` outside FETCH/MEM are ignored.
- `Zero` is sampled only in EXEC of beq/bne.
- Op/Funct must be stable from the cycle after `IRWrite` until the next FETCH.

## Test plan
- Reset release with add (Op=0, Funct=100000), zero-wait memory -> IDLE, FETCH, DECODE, EXEC, WB. WB has `RegWrite`=1, ALUOp=0001, GPRSel=00, `PCWrite`=1. `instret`=1.
- lw with `dmem_ready` held low 3 MEM cycles -> `dmem_req` high for 4 cycles, `MemWrite`=0. `MDRWrite` pulses on the 4th cycle. Then WB with WDSel=01, GPRSel=01. Total 8 cycles.
- beq with Zero=1, then beq with Zero=0 -> NPCOp=01 then 00, each with `PCWrite` in EXEC. 3 cycles each.
- jal -> in EXEC: `RegWrite`=1, GPRSel=10, WDSel=10, NPCOp=10, `PCWrite`=1.
- Op=111111 -> DECODE asserts `PCWrite` with NPCOp=00. `illegal`=1 and stays 1 through a following legal sw. `instret` counts both.
- `rstn` pulsed low during MEM of sw -> `dmem_req`/`MemWrite` drop asynchronously, `instret` returns to 0, and the state is IDLE after release.
